conv_encoder_block: RTL and testbench

Parametrised rate-1/2 convolutional encoder. It is the next generation of the fixed 64-to-128-bit start/done encoder used at the top level.
- Accepts one DATA_W-bit block on a start pulse and encodes it MSB-first, BITS_PER_CYC bits per clock.
- Presents a 2*DATA_W-bit codeword with a held done flag.
- Adds a configurable constraint length and generators, selectable per-block state reset or streaming, and a busy indication.

---
 rtl/conv_encoder_block.sv | 142 ++++++++++++++
 tb/tb_conv_encoder_block.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_block.sv
// conv_encoder_block: rate-1/2 convolutional encoder with a start/done handshake.
// Encodes one DATA_W-bit block MSB-first, BITS_PER_CYC bits per clock, into a
// 2*DATA_W-bit codeword that is held together with a done flag.
// Optional feature: define CONV_ENC_BLKCNT_EN to add a 16-bit completed-block
// counter on port blk_count.
module conv_encoder_block #(
  parameter int             DATA_W       = 64,
  parameter int             K            = 3,
  parameter logic [K-1:0]   G0           = 3'b111,
  parameter logic [K-1:0]   G1           = 3'b101,
  parameter int             BITS_PER_CYC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [DATA_W-1:0]   data_in,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] final_output
`ifdef CONV_ENC_BLKCNT_EN
  ,
  output logic [15:0]         blk_count
`endif
);

  localparam int CYCLES = DATA_W / BITS_PER_CYC;
  localparam int CNT_W  = $clog2(CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [K-2:0]          encState_q, encState_d;
  logic [CNT_W-1:0]      bitCnt_q, bitCnt_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [2*DATA_W-1:0]   final_q, final_d;
  logic                  done_q, done_d;

  logic [K-1:0]          win;
  logic [K-2:0]          encStep;
  logic [2*DATA_W-1:0]   accStep;
  logic                  lastStep;

  // The final RUN cycle is the one that consumes the last group of input bits.
  assign lastStep = (state_q == RUN) && (bitCnt_q == CNT_W'(CYCLES - 1));

  // Register update; reset clears the FSM, encoder memory and the held codeword.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      encState_q <= '0;
      bitCnt_q   <= '0;
      acc_q      <= '0;
      final_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      encState_q <= encState_d;
      bitCnt_q   <= bitCnt_d;
      acc_q      <= acc_d;
      final_q    <= final_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic: accept a block in IDLE/DONE, encode a bit group per RUN cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    encState_d = encState_q;
    bitCnt_d   = bitCnt_q;
    acc_d      = acc_q;
    final_d    = final_q;
    done_d     = done_q;
    win        = '0;
    encStep    = encState_q;
    accStep    = acc_q;

    // Pairs are shifted in at the bottom, so after the whole block the first
    // processed bit's pair has reached the top of the accumulator.
    for (int j = 0; j < BITS_PER_CYC; j++) begin
      win     = {shift_q[DATA_W-1-j], encStep};
      accStep = {accStep[2*DATA_W-3:0], ^(win & G0), ^(win & G1)};
      encStep = win[K-1:1];
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shift_d  = data_in;
          bitCnt_d = '0;
          done_d   = 1'b0;
          state_d  = RUN;
          if (!mode) begin
            encState_d = '0;
          end
        end
      end
      RUN: begin
        shift_d    = shift_q << BITS_PER_CYC;
        encState_d = encStep;
        acc_d      = accStep;
        bitCnt_d   = bitCnt_q + 1'b1;
        if (lastStep) begin
          final_d = accStep;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign final_output = final_q;

`ifdef CONV_ENC_BLKCNT_EN
  logic [15:0] blkCnt_q;

  // Completed-block counter, bumped on the same edge that raises done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blkCnt_q <= '0;
    end else if (lastStep) begin
      blkCnt_q <= blkCnt_q + 16'd1;
    end
  end

  assign blk_count = blkCnt_q;
`endif

endmodule

// File: tb/tb_conv_encoder_block.sv
// tb_conv_encoder_block: directed self-checking bench for conv_encoder_block.
// Instance A uses the defaults (1 bit per cycle), instance B uses 4 bits per cycle.
module tb_conv_encoder_block;

  logic          clk;
  logic          rst_n;
  logic          startA, modeA, startB, modeB;
  logic [63:0]   dataA, dataB;
  logic          busyA, doneA, busyB, doneB;
  logic [127:0]  finalA, finalB;
`ifdef CONV_ENC_BLKCNT_EN
  logic [15:0]   blkCntA, blkCntB;
`endif

  int compCount = 0;
  int failCount = 0;

  localparam logic [127:0] CW_MSB  = {8'hEC, 120'h0};
  localparam logic [127:0] CW_ONES = {8'hDA, {30{4'hA}}};
  localparam logic [127:0] CW_TAIL = {8'h70, 120'h0};
  localparam logic [63:0]  D_MSB   = 64'h8000_0000_0000_0000;
  localparam logic [63:0]  D_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  conv_encoder_block dutA (
    .clk          (clk),
    .reset        (rst_n),
    .start        (startA),
    .mode         (modeA),
    .data_in      (dataA),
    .busy         (busyA),
    .done         (doneA),
    .final_output (finalA)
`ifdef CONV_ENC_BLKCNT_EN
    ,
    .blk_count    (blkCntA)
`endif
  );

  conv_encoder_block #(.BITS_PER_CYC(4)) dutB (
    .clk          (clk),
    .reset        (rst_n),
    .start        (startB),
    .mode         (modeB),
    .data_in      (dataB),
    .busy         (busyB),
    .done         (doneB),
    .final_output (finalB)
`ifdef CONV_ENC_BLKCNT_EN
    ,
    .blk_count    (blkCntB)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one block on the chosen instance. lat counts clock edges from the
  // accepting edge (counted as 1) until done is seen; busyCyc counts busy cycles.
  task automatic applyStimulus(input bit useFast, input logic [63:0] data, input logic m,
                               output int lat, output int busyCyc);
    lat = 0;
    busyCyc = 0;
    @(negedge clk);
    if (useFast) begin
      startB = 1'b1; dataB = data; modeB = m;
    end else begin
      startA = 1'b1; dataA = data; modeA = m;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
    while (!(useFast ? doneB : doneA) && lat < 200) begin
      if (useFast ? busyB : busyA) busyCyc++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, busyCyc, doneSeen;
    startA = 1'b0; modeA = 1'b0; dataA = '0;
    startB = 1'b0; modeB = 1'b0; dataB = '0;
    rst_n  = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_busyA",  128'(busyA),  128'd0);
    checkOutput("rst_doneA",  128'(doneA),  128'd0);
    checkOutput("rst_finalA", finalA,       128'd0);
    checkOutput("rst_finalB", finalB,       128'd0);
`ifdef CONV_ENC_BLKCNT_EN
    checkOutput("rst_blkcnt", 128'(blkCntA), 128'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single leading one, cleared state
    applyStimulus(1'b0, D_MSB, 1'b0, lat, busyCyc);
    checkOutput("msb_cw",   finalA,         CW_MSB);
    checkOutput("msb_lat",  128'(lat),      128'd65);
    checkOutput("msb_busy", 128'(busyCyc),  128'd64);
    checkOutput("msb_done", 128'(doneA),    128'd1);

    // Done and codeword hold while idle in DONE
    repeat (5) @(negedge clk);
    checkOutput("hold_done", 128'(doneA), 128'd1);
    checkOutput("hold_cw",   finalA,      CW_MSB);

    // All ones, then streaming continuation, then cleared
    applyStimulus(1'b0, D_ONES, 1'b0, lat, busyCyc);
    checkOutput("ones_cw",  finalA, CW_ONES);
    applyStimulus(1'b0, 64'h0, 1'b1, lat, busyCyc);
    checkOutput("stream_cw", finalA, CW_TAIL);
    applyStimulus(1'b0, 64'h0, 1'b0, lat, busyCyc);
    checkOutput("zero_cw",  finalA, 128'd0);

    // Start pulse at cycle 20 of RUN must be ignored
    @(negedge clk);
    startA = 1'b1; dataA = D_MSB; modeA = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    startA = 1'b0;
    while (!doneA && lat < 200) begin
      if (lat == 20) begin
        startA = 1'b1; dataA = D_ONES; modeA = 1'b0;
      end else begin
        startA = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    startA = 1'b0;
    checkOutput("ign_cw",  finalA,    CW_MSB);
    checkOutput("ign_lat", 128'(lat), 128'd65);

    // Reset at cycle 30 of an all-ones block
    @(negedge clk);
    startA = 1'b1; dataA = D_ONES; modeA = 1'b0;
    @(negedge clk);
    startA = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy",  128'(busyA), 128'd0);
    checkOutput("mid_rst_done",  128'(doneA), 128'd0);
    checkOutput("mid_rst_final", finalA,      128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, D_MSB, 1'b1, lat, busyCyc);
    checkOutput("post_rst_cw", finalA, CW_MSB);

    // Four bits per cycle
    applyStimulus(1'b1, D_MSB, 1'b0, lat, busyCyc);
    checkOutput("fast_msb_cw",  finalB,    CW_MSB);
    checkOutput("fast_msb_lat", 128'(lat), 128'd17);
    applyStimulus(1'b1, D_ONES, 1'b0, lat, busyCyc);
    checkOutput("fast_ones_cw",   finalB,        CW_ONES);
    checkOutput("fast_ones_lat",  128'(lat),     128'd17);
    checkOutput("fast_ones_busy", 128'(busyCyc), 128'd16);

`ifdef CONV_ENC_BLKCNT_EN
    // Back-to-back blocks with start held high
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("cnt_rst", 128'(blkCntA), 128'd0);
    rst_n = 1'b1;
    startA = 1'b1; dataA = D_MSB; modeA = 1'b0;
    doneSeen = 0;
    lat = 0;
    while (doneSeen < 3 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (doneA) begin
        doneSeen++;
        checkOutput($sformatf("cnt_blk%0d", doneSeen), 128'(blkCntA), 128'(doneSeen));
        checkOutput($sformatf("cnt_cw%0d", doneSeen), finalA, CW_MSB);
      end
    end
    startA = 1'b0;
    checkOutput("cnt_blocks", 128'(doneSeen), 128'd3);
`else
    doneSeen = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
